// File: rtl/uart_pkg.sv
// Shared definitions for the UART stimulus path: serialiser state encoding
// and the 8N1 line levels (start bit 0, data LSB first, one stop bit 1).
package uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_e;

    localparam logic IDLE_LEVEL = 1'b1;
    localparam logic START_BIT  = 1'b0;
    localparam logic STOP_BIT   = 1'b1;

endpackage

// File: rtl/sync_fifo.sv
// Small circular-buffer FIFO with registered level/full/empty flags and a
// one-cycle overflow pulse for pushes dropped while full.
module sync_fifo #(
    parameter int N     = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_push,
    input  logic [N-1:0]             i_data,
    input  logic                     i_pop,
    output logic [N-1:0]             o_head,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_level,
    output logic                     o_overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);

    logic [N-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   level_q, level_d;
    logic          full_q, empty_q, overflow_q;
    logic          do_push, do_pop;

    // A full FIFO drops the push even when a pop frees a slot on the same edge.
    assign do_push = i_push && !full_q;
    assign do_pop  = i_pop && !empty_q;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        level_d = level_q;
        if (do_push && !do_pop) begin
            level_d = level_q + 1'b1;
        end else if (!do_push && do_pop) begin
            level_d = level_q - 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            overflow_q <= 1'b0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            level_q    <= level_d;
            full_q     <= (level_d == FULL_LEVEL);
            empty_q    <= (level_d == '0);
            overflow_q <= i_push && full_q;
        end
    end

    // NOTE: storage is not reset; the pointers and level define which entries are valid.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= i_data;
    end

    assign o_head     = mem_q[rd_ptr_q];
    assign o_full     = full_q;
    assign o_empty    = empty_q;
    assign o_level    = level_q;
    assign o_overflow = overflow_q;

endmodule

// File: rtl/uart_rx_stim_driver.sv
// Queues parallel bytes and serialises them as 8N1 frames on o_rx, one bit
// per TICKS_PER_BIT baud ticks, with back-to-back frames when data is waiting.
module uart_rx_stim_driver
    import uart_pkg::*;
#(
    parameter int N             = 8,
    parameter int TICKS_PER_BIT = 16,
    parameter int DEPTH         = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_tick,
    input  logic [N-1:0]             i_data,
    input  logic                     i_push,
    output logic                     o_full,
    output logic [$clog2(DEPTH):0]   o_level,
    output logic                     o_overflow,
    output logic                     o_rx,
    output logic                     o_busy,
    output logic                     o_frame_done
);

    localparam int TW = (TICKS_PER_BIT > 1) ? $clog2(TICKS_PER_BIT) : 1;
    localparam int BW = (N > 1) ? $clog2(N) : 1;
    localparam logic [TW-1:0] TC_LAST = TW'(TICKS_PER_BIT - 1);
    localparam logic [BW-1:0] BI_LAST = BW'(N - 1);

    tx_state_e     state_q;
    logic [TW-1:0] tc_q;
    logic [BW-1:0] bi_q;
    logic [N-1:0]  sr_q;
    logic          rx_q, busy_q, frame_done_q;

    logic          fifo_pop, fifo_empty;
    logic [N-1:0]  fifo_head;
    logic          bit_end;

    assign bit_end = i_tick && (tc_q == TC_LAST);

    // A new frame starts on a tick from IDLE, or directly on the final stop tick.
    always_comb begin
        fifo_pop = 1'b0;
        if (!fifo_empty) begin
            case (state_q)
                ST_IDLE: fifo_pop = i_tick;
                ST_STOP: fifo_pop = bit_end;
                default: fifo_pop = 1'b0;
            endcase
        end
    end

    sync_fifo #(
        .N     (N),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .i_push     (i_push),
        .i_data     (i_data),
        .i_pop      (fifo_pop),
        .o_head     (fifo_head),
        .o_full     (o_full),
        .o_empty    (fifo_empty),
        .o_level    (o_level),
        .o_overflow (o_overflow)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            tc_q         <= '0;
            bi_q         <= '0;
            sr_q         <= '0;
            rx_q         <= IDLE_LEVEL;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (fifo_pop) begin
                        sr_q    <= fifo_head;
                        tc_q    <= '0;
                        state_q <= ST_START;
                        rx_q    <= START_BIT;
                        busy_q  <= 1'b1;
                    end
                end
                ST_START: begin
                    if (bit_end) begin
                        tc_q    <= '0;
                        bi_q    <= '0;
                        state_q <= ST_DATA;
                        rx_q    <= sr_q[0];
                    end else if (i_tick) begin
                        tc_q <= tc_q + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (bit_end) begin
                        tc_q <= '0;
                        if (bi_q == BI_LAST) begin
                            state_q <= ST_STOP;
                            rx_q    <= STOP_BIT;
                        end else begin
                            // Shift so the bit on the line is always sr_q[0].
                            bi_q <= bi_q + 1'b1;
                            sr_q <= {1'b0, sr_q[N-1:1]};
                            rx_q <= sr_q[1];
                        end
                    end else if (i_tick) begin
                        tc_q <= tc_q + 1'b1;
                    end
                end
                ST_STOP: begin
                    if (bit_end) begin
                        tc_q         <= '0;
                        frame_done_q <= 1'b1;
                        if (fifo_pop) begin
                            sr_q    <= fifo_head;
                            state_q <= ST_START;
                            rx_q    <= START_BIT;
                        end else begin
                            state_q <= ST_IDLE;
                            rx_q    <= IDLE_LEVEL;
                            busy_q  <= 1'b0;
                        end
                    end else if (i_tick) begin
                        tc_q <= tc_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    rx_q    <= IDLE_LEVEL;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign o_rx         = rx_q;
    assign o_busy       = busy_q;
    assign o_frame_done = frame_done_q;

endmodule

// File: tb/tb_uart_rx_stim_driver.sv
// Bench for uart_rx_stim_driver: directed frame vectors, multi-cycle corner
// sequences and a randomized run against a frame-timing reference model.
module tb_uart_rx_stim_driver;

    localparam int N     = 8;
    localparam int T     = 16;
    localparam int DEPTH = 4;
    localparam int LW    = $clog2(DEPTH) + 1;
    localparam int FB    = (N + 2) * T;

    logic          clk, reset, i_tick, i_push;
    logic [N-1:0]  i_data;
    logic          o_full, o_overflow, o_rx, o_busy, o_frame_done;
    logic [LW-1:0] o_level;

    uart_rx_stim_driver #(.N(N), .TICKS_PER_BIT(T), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .reset        (reset),
        .i_tick       (i_tick),
        .i_data       (i_data),
        .i_push       (i_push),
        .o_full       (o_full),
        .o_level      (o_level),
        .o_overflow   (o_overflow),
        .o_rx         (o_rx),
        .o_busy       (o_busy),
        .o_frame_done (o_frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [7:0] data;
        logic [9:0] frame;  // line levels in send order, bit 0 first
    } vec_t;
    vec_t vecs[8];

    // Tick source: 0 none, 1 every other cycle, 2 every cycle, 3 random.
    int tick_mode = 0;
    int tick_div  = 0;
    always @(negedge clk) begin
        case (tick_mode)
            0: i_tick = 1'b0;
            1: begin tick_div++; i_tick = tick_div[0]; end
            2: i_tick = 1'b1;
            default: i_tick = ($urandom_range(0, 2) == 0);
        endcase
    end

    // Reference model: a byte queue plus "ticks left in current frame".
    logic [7:0] mq[$];
    logic [7:0] cur = '0;
    int         rem = 0;
    logic       s_rx[$];
    logic       s_fd[$];

    function automatic logic model_rx(input int rem_v, input logic [7:0] cur_v);
        int k, b;
        if (rem_v == 0) return 1'b1;
        k = FB - rem_v;
        b = k / T;
        if (b == 0) return 1'b0;
        if (b == N + 1) return 1'b1;
        return cur_v[b-1];
    endfunction

    function automatic logic [9:0] make_frame(input logic [7:0] b);
        return {1'b1, b, 1'b0};
    endfunction

    always @(posedge clk) begin : model
        logic t, p, full_pre, efd, eovf;
        logic [7:0] d, act, exp;
        t = i_tick; p = i_push; d = i_data;
        if (!reset) begin
            mq.delete();
            rem = 0;
        end else begin
            full_pre = (mq.size() == DEPTH);
            efd = 1'b0;
            if (t) begin
                if (rem > 0) begin
                    rem--;
                    efd = (rem == 0);
                end
                if (rem == 0 && mq.size() > 0) begin
                    cur = mq.pop_front();
                    rem = FB;
                end
            end
            eovf = p && full_pre;
            if (p && !full_pre) mq.push_back(d);
            #1;
            exp = {model_rx(rem, cur), rem > 0, mq.size() == DEPTH, eovf, efd, LW'(mq.size())};
            act = {o_rx, o_busy, o_full, o_overflow, o_frame_done, o_level};
            check("cycle", act, exp);
            if (t) begin
                s_rx.push_back(o_rx);
                s_fd.push_back(o_frame_done);
            end
        end
    end

    task automatic drive_push(input logic [7:0] b);
        i_push = 1'b1;
        i_data = b;
        @(negedge clk);
    endtask

    task automatic end_push();
        i_push = 1'b0;
        i_data = 8'($urandom);
    endtask

    task automatic wait_idle(input int budget, input string name);
        int c = 0;
        while ((o_busy !== 1'b0 || o_level !== '0) && c < budget) begin
            @(negedge clk);
            c++;
        end
        check(name, c < budget, 1'b1);
    endtask

    task automatic wait_samples(input int n, input int budget, input string name);
        int c = 0;
        while (s_rx.size() < n && c < budget) begin
            @(negedge clk);
            c++;
        end
        check(name, c < budget, 1'b1);
    endtask

    task automatic wait_fd(input int budget, input string name);
        int c = 0;
        do begin
            @(negedge clk);
            c++;
        end while (o_frame_done !== 1'b1 && c < budget);
        check(name, c < budget, 1'b1);
    endtask

    function automatic int find_start();
        int i = 0;
        while (i < s_rx.size() && s_rx[i] !== 1'b0) i++;
        return i;
    endfunction

    function automatic int count_fd();
        int n = 0;
        foreach (s_fd[i]) if (s_fd[i] === 1'b1) n++;
        return n;
    endfunction

    // Each of the ten bit periods must hold its level for all T tick samples.
    task automatic analyze_frame(input int base, input logic [9:0] frame, input string tag);
        int m;
        if (base + 10 * T > s_rx.size()) begin
            check({tag, "_short"}, s_rx.size(), base + 10 * T);
            return;
        end
        for (int b = 0; b < 10; b++) begin
            m = 0;
            for (int j = 0; j < T; j++) if (s_rx[base + b * T + j] === frame[b]) m++;
            check($sformatf("%s_bit%0d", tag, b), m, T);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int i0, bad, r;
        string tag;

        vecs[0] = '{8'hA5, 10'b1101001010};
        vecs[1] = '{8'h00, 10'b1000000000};
        vecs[2] = '{8'hFF, 10'b1111111110};
        vecs[3] = '{8'h3C, 10'b1001111000};
        vecs[4] = '{8'h81, 10'b1100000010};
        vecs[5] = '{8'h05, 10'b1000001010};
        vecs[6] = '{8'h03, 10'b1000000110};
        vecs[7] = '{8'h20, 10'b1001000000};

        reset = 1'b0; i_push = 1'b0; i_data = '0; i_tick = 1'b0;
        repeat (5) @(negedge clk);
        check("reset_state", {o_rx, o_busy, o_full, o_overflow, o_frame_done, o_level}, 8'h80);
        reset = 1'b1;

        // Idle line with ticks but nothing queued.
        tick_mode = 2;
        bad = 0;
        repeat (1000) begin
            @(negedge clk);
            if (o_rx !== 1'b1 || o_busy !== 1'b0 || o_level !== '0 || o_full !== 1'b0) bad++;
        end
        check("idle_1000_ticks", bad, 0);

        // Single frames from the table.
        tick_mode = 1;
        for (int v = 0; v < 8; v++) begin
            tag = $sformatf("vec%0d", v);
            wait_idle(4000, {tag, "_idle_wait"});
            s_rx.delete(); s_fd.delete();
            drive_push(vecs[v].data);
            end_push();
            wait_samples(FB + 4, 8 * FB, {tag, "_sample_wait"});
            i0 = find_start();
            check({tag, "_start_latency"}, i0 <= 1, 1'b1);
            analyze_frame(i0, vecs[v].frame, tag);
            check({tag, "_fd_count"}, count_fd(), 1);
            if (i0 + FB < s_fd.size()) check({tag, "_fd_pos"}, s_fd[i0 + FB], 1'b1);
            repeat (4) @(negedge clk);
            check({tag, "_busy_after"}, o_busy, 1'b0);
        end

        // Three bytes back-to-back, frames contiguous.
        tick_mode = 0;
        wait_idle(4000, "b2b_idle_wait");
        repeat (2) @(negedge clk);
        s_rx.delete(); s_fd.delete();
        for (int k = 5; k < 8; k++) drive_push(vecs[k].data);
        end_push();
        check("b2b_level3", o_level, 3);
        tick_mode = 1;
        begin
            int c = 0;
            while (o_busy !== 1'b1 && c < 50) begin @(negedge clk); c++; end
            check("b2b_busy_wait", c < 50, 1'b1);
        end
        check("b2b_level2", o_level, 2);
        wait_fd(4 * FB, "b2b_fd1_wait");
        check("b2b_level1", o_level, 1);
        wait_fd(4 * FB, "b2b_fd2_wait");
        check("b2b_level0", o_level, 0);
        wait_fd(4 * FB, "b2b_fd3_wait");
        check("b2b_busy_end", o_busy, 1'b0);
        i0 = find_start();
        for (int k = 0; k < 3; k++) analyze_frame(i0 + k * FB, vecs[5 + k].frame, $sformatf("b2b_f%0d", k));
        check("b2b_fd_count", count_fd(), 3);
        if (i0 + 3 * FB < s_fd.size()) check("b2b_fd3_pos", s_fd[i0 + 3 * FB], 1'b1);

        // Overflow: five pushes into four entries with ticks stopped.
        tick_mode = 0;
        repeat (2) @(negedge clk);
        s_rx.delete(); s_fd.delete();
        drive_push(8'h11); drive_push(8'h22); drive_push(8'h33); drive_push(8'h44);
        check("ovf_full_level", {o_full, o_level}, {1'b1, LW'(4)});
        check("ovf_quiet", o_overflow, 1'b0);
        drive_push(8'h55);
        check("ovf_pulse", o_overflow, 1'b1);
        end_push();
        @(negedge clk);
        check("ovf_pulse_end", o_overflow, 1'b0);
        tick_mode = 2;
        wait_idle(6 * FB, "ovf_drain_wait");
        repeat (2 * FB) @(negedge clk);
        check("ovf_fd_count", count_fd(), 4);
        i0 = find_start();
        analyze_frame(i0,          make_frame(8'h11), "ovf_f0");
        analyze_frame(i0 + 3 * FB, make_frame(8'h44), "ovf_f3");

        // Asynchronous reset in the middle of data bit 3 with a byte still queued.
        tick_mode = 1;
        repeat (2) @(negedge clk);
        s_rx.delete(); s_fd.delete();
        drive_push(8'hFF); drive_push(8'hFF);
        end_push();
        wait_samples(4 * T + 8, 8 * FB, "rst_sample_wait");
        @(negedge clk);
        check("rst_pre_busy", o_busy, 1'b1);
        #3 reset = 1'b0;
        #1 check("rst_async", {o_rx, o_busy, o_full, o_overflow, o_frame_done, o_level}, 8'h80);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        tick_mode = 2;
        bad = 0;
        repeat (300) begin
            @(negedge clk);
            if (o_rx !== 1'b1 || o_busy !== 1'b0 || o_level !== '0) bad++;
        end
        check("rst_stays_idle", bad, 0);

        // Randomized traffic against the model, sparse then heavy.
        tick_mode = 3;
        for (int cyc = 0; cyc < 20000; cyc++) begin
            @(negedge clk);
            r = $urandom_range(0, 99);
            i_push = (r < ((cyc < 10000) ? 1 : 8));
            i_data = 8'($urandom);
        end
        end_push();
        wait_idle(8000, "rand_drain_wait");
        repeat (10) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
